// File: rtl/act_serializer_pkg.sv
// rtl/act_serializer_pkg.sv - shared constants, FSM encoding and helpers for act_serializer
package act_serializer_pkg;

  // Lanes on the MAC result bus; fixed in this revision.
  localparam int CLASS_NUM = 8;

  // Integer bits beyond the 16 fractional/base bits of a lane.
  localparam int FEATURE_WIDE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_BIAS   = 2'd2
  } state_t;

  // Lane width derived from the extra integer bits.
  function automatic int lane_width(input int feature_wide);
    return feature_wide + 16;
  endfunction

  // Low bit of lane k in the flattened result bus.
  function automatic int lane_lo(input int k, input int lw);
    return k * lw;
  endfunction

  // Valid-lane count limited to the number of physical lanes.
  function automatic logic [4:0] clamp_nv(input logic [3:0] n);
    return (n > 4'd8) ? 5'd8 : {1'b0, n};
  endfunction

endpackage

// File: rtl/act_serializer_if.sv
// rtl/act_serializer_if.sv - serial feature stream towards the next layer MAC
interface act_serializer_if #(
  parameter int LW     = 20,
  parameter int ADDR_W = 5
) ();

  logic              out_valid;
  logic              out_ready;
  logic signed [LW-1:0] feature;
  logic              bias_beat;
  logic              last;
  logic [ADDR_W-1:0] w_addr;

  modport master (
    output out_valid,
    output feature,
    output bias_beat,
    output last,
    output w_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  feature,
    input  bias_beat,
    input  last,
    input  w_addr,
    output out_ready
  );

endinterface

// File: rtl/act_serializer_relu_lane.sv
// rtl/act_serializer_relu_lane.sv - combinational ReLU on one signed lane
module relu_lane #(
  parameter int LW = 20
) (
  input  logic [LW-1:0] i_lane,
  output logic [LW-1:0] o_lane
);

  // Only the sign bit decides; non-negative values pass through unchanged.
  assign o_lane = i_lane[LW-1] ? '0 : i_lane;

endmodule

// File: rtl/act_serializer.sv
// rtl/act_serializer.sv - captures MAC lane sums, applies ReLU and replays them as a serial stream
module act_serializer
  import act_serializer_pkg::*;
#(
  parameter  int FEATURE_WIDE = FEATURE_WIDE_DEF,
  parameter  int BIAS_BEAT    = 1,
  parameter  int ADDR_W       = 5,
  localparam int LW           = lane_width(FEATURE_WIDE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [CLASS_NUM*LW-1:0] result,
  input  logic [3:0]            n_valid,
  act_serializer_if.master      m_out,
  output logic [4:0]            f_num,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam bit LP_BIAS = (BIAS_BEAT != 0);

  state_t        r_state;
  state_t        w_next;
  logic [LW-1:0] r_buf [CLASS_NUM];
  logic [LW-1:0] w_relu [CLASS_NUM];
  logic [4:0]    r_idx;
  logic [4:0]    r_nv;
  logic          r_done;
  logic          r_overrun;
  logic [4:0]    w_nv;
  logic          w_hs;
  logic          w_accept;
  logic          w_last_lane;
  logic          w_final;

  assign w_nv        = clamp_nv(n_valid);
  assign w_hs        = m_out.out_valid & m_out.out_ready;
  assign w_accept    = load & (r_state == ST_IDLE);
  assign w_last_lane = (r_idx == (r_nv - 5'd1));
  // Final handshake of a vector: the bias beat, or the last lane when no bias beat follows.
  assign w_final     = w_hs & ((r_state == ST_BIAS) |
                               ((r_state == ST_STREAM) & w_last_lane & ~LP_BIAS));

  for (genvar k = 0; k < CLASS_NUM; k++) begin : g_lane
    relu_lane #(.LW(LW)) u_relu (
      .i_lane (result[lane_lo(k, LW) +: LW]),
      .o_lane (w_relu[k])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decision: capture, stream lanes, then optional bias beat.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          if (w_nv != 5'd0) w_next = ST_STREAM;
          else if (LP_BIAS) w_next = ST_BIAS;
        end
      end
      ST_STREAM: begin
        if (w_hs && w_last_lane) w_next = LP_BIAS ? ST_BIAS : ST_IDLE;
      end
      ST_BIAS: begin
        if (w_hs) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Buffer capture, beat index and feature count; the index runs up to nv so it doubles as the bias address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CLASS_NUM; k++) r_buf[k] <= '0;
      r_idx <= '0;
      r_nv  <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < CLASS_NUM; k++) r_buf[k] <= w_relu[k];
      r_idx <= '0;
      r_nv  <= w_nv;
    end else if (w_hs && (r_state == ST_STREAM)) begin
      r_idx <= r_idx + 5'd1;
    end
  end

  // Done pulse after the final handshake (or an empty vector with no bias beat); sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= w_final | (w_accept & (w_nv == 5'd0) & ~LP_BIAS);
      r_overrun <= r_overrun | (load & (r_state != ST_IDLE));
    end
  end

  // Beat outputs decoded from registered state so they stay stable through a stall.
  always_comb begin
    m_out.out_valid = (r_state != ST_IDLE);
    m_out.bias_beat = (r_state == ST_BIAS);
    m_out.feature   = '0;
    m_out.w_addr    = ADDR_W'(r_idx);
    m_out.last      = (r_state == ST_BIAS) | ((r_state == ST_STREAM) & w_last_lane & ~LP_BIAS);
    if (r_state == ST_STREAM) m_out.feature = r_buf[r_idx[2:0]];
  end

  assign f_num   = r_nv;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_act_serializer.sv
// tb/tb_act_serializer.sv - scoreboard bench for act_serializer with and without bias beat
module tb_act_serializer;
  import act_serializer_pkg::*;

  localparam int LW = 20;
  localparam int AW = 5;

  typedef struct packed {
    logic signed [LW-1:0] feature;
    logic                 bias;
    logic                 last;
    logic [AW-1:0]        addr;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load = 1'b0;
  logic            ready = 1'b0;
  logic [8*LW-1:0] result = '0;
  logic [3:0]      n_valid = '0;

  logic [4:0] f_num_a, f_num_b;
  logic       busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

  act_serializer_if #(.LW(LW), .ADDR_W(AW)) if_a ();
  act_serializer_if #(.LW(LW), .ADDR_W(AW)) if_b ();

  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;

  act_serializer #(.FEATURE_WIDE(4), .BIAS_BEAT(1), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .result(result), .n_valid(n_valid),
    .m_out(if_a), .f_num(f_num_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  act_serializer #(.FEATURE_WIDE(4), .BIAS_BEAT(0), .ADDR_W(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .result(result), .n_valid(n_valid),
    .m_out(if_b), .f_num(f_num_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  beat_t q_a[$];
  beat_t q_b[$];
  int    checks = 0;
  int    errors = 0;
  bit    hs_pend[2];
  bit    dn_sched[2];
  bit    dn_now[2];
  bit    ovr_m[2];
  int    fnum_m[2];
  int    ready_mode = 0;
  int    rcnt = 0;

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? q_a.size() : q_b.size();
  endfunction

  // Expected beats: ReLU of each valid lane in order, then the bias beat for instance 0.
  task automatic push_vec(input int inst, input logic [8*LW-1:0] res, input int n);
    int    nv;
    beat_t b;
    nv = (n > 8) ? 8 : n;
    for (int k = 0; k < nv; k++) begin
      logic signed [LW-1:0] v;
      v = res[k*LW +: LW];
      b.feature = (v < 0) ? '0 : v;
      b.bias    = 1'b0;
      b.last    = (k == nv - 1) && (inst == 1);
      b.addr    = AW'(k);
      if (inst == 0) q_a.push_back(b); else q_b.push_back(b);
    end
    if (inst == 0) begin
      b.feature = '0;
      b.bias    = 1'b1;
      b.last    = 1'b1;
      b.addr    = AW'(nv);
      q_a.push_back(b);
    end
  endtask

  task automatic do_load(input logic [8*LW-1:0] res, input logic [3:0] n);
    int nv;
    @(posedge clk); #2;
    result  = res;
    n_valid = n;
    load    = 1'b1;
    @(posedge clk);
    nv = (n > 8) ? 8 : int'(n);
    for (int i = 0; i < 2; i++) begin
      if (qsize(i) == 0 && !hs_pend[i]) begin
        push_vec(i, res, int'(n));
        fnum_m[i] = nv;
        if (nv == 0 && i == 1) dn_now[i] = 1'b1;
      end else begin
        ovr_m[i] = 1'b1;
      end
    end
    #2 load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: queues a=%0d b=%0d still pending, required 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_qa_le(input int lim);
    int n;
    n = 0;
    while (q_a.size() > lim && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_qa: size %0d, required <= %0d", q_a.size(), lim);
    end
  endtask

  function automatic logic [8*LW-1:0] pack8(input int v[8]);
    logic [8*LW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*LW +: LW] = LW'(v[k]);
    return r;
  endfunction

  function automatic logic [8*LW-1:0] rand_lanes();
    logic [8*LW-1:0] r;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) r[k*LW +: LW] = LW'($urandom);
      else r[k*LW +: LW] = LW'(int'($urandom_range(0, 200)) - 100);
    end
    return r;
  endfunction

  // Downstream ready: always on, random, or the 1,0,0,1 stall pattern.
  always @(posedge clk) begin
    #2;
    rcnt++;
    if (ready_mode == 0) ready = 1'b1;
    else if (ready_mode == 1) ready = ($urandom_range(0, 3) != 0);
    else ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
  end

  // Monitor: compares the presented beat with the scoreboard head every cycle, pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic       ov, bz, dn, oo;
        logic [4:0] fn;
        beat_t      act, e;
        int         sz;
        bit         exp_dn;
        ov  = i ? if_b.out_valid : if_a.out_valid;
        bz  = i ? busy_b : busy_a;
        dn  = i ? done_b : done_a;
        oo  = i ? ovr_b : ovr_a;
        fn  = i ? f_num_b : f_num_a;
        act.feature = i ? if_b.feature : if_a.feature;
        act.bias    = i ? if_b.bias_beat : if_a.bias_beat;
        act.last    = i ? if_b.last : if_a.last;
        act.addr    = i ? if_b.w_addr : if_a.w_addr;
        sz = qsize(i);
        exp_dn = dn_sched[i] | dn_now[i];
        dn_now[i]   = 1'b0;
        dn_sched[i] = 1'b0;
        hs_pend[i]  = 1'b0;
        chk("done", i, dn, exp_dn);
        chk("out_valid", i, ov, sz != 0);
        chk("busy", i, bz, sz != 0);
        chk("overrun", i, oo, ovr_m[i]);
        chk("f_num", i, fn, fnum_m[i]);
        if (ov && sz != 0) begin
          e = (i == 0) ? q_a[0] : q_b[0];
          chk("feature", i, act.feature, e.feature);
          chk("bias_beat", i, act.bias, e.bias);
          chk("last", i, act.last, e.last);
          chk("w_addr", i, act.addr, e.addr);
          if (ready) begin
            if (i == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
            hs_pend[i]  = 1'b1;
            dn_sched[i] = e.last;
          end
        end
      end
    end
  end

  initial begin
    int v1[8];
    int v2[8];
    logic [8*LW-1:0] r;
    v1 = '{5, -3, 0, 100, -1, 7, 8, -9};
    v2 = '{10, 20, 30, 40, 50, 60, 70, 80};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 0, if_a.out_valid, 0);
    chk("rst_out_valid", 1, if_b.out_valid, 0);
    chk("rst_busy", 0, busy_a, 0);
    chk("rst_done", 0, done_a, 0);
    chk("rst_overrun", 0, ovr_a, 0);
    chk("rst_f_num", 0, f_num_a, 0);
    chk("rst_f_num", 1, f_num_b, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    ready_mode = 0;
    do_load(pack8(v1), 4'd8);
    wait_idle();

    do_load(pack8(v2), 4'd3);
    wait_idle();

    ready_mode = 2;
    do_load(pack8(v1), 4'd8);
    wait_idle();
    ready_mode = 0;

    do_load(pack8(v2), 4'd8);
    wait_qa_le(8);
    do_load(pack8(v1), 4'd8);
    wait_idle();

    do_load(pack8(v1), 4'd8);
    wait_qa_le(5);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 0, if_a.out_valid, 0);
    chk("rst_mid_out_valid", 1, if_b.out_valid, 0);
    chk("rst_mid_busy", 0, busy_a, 0);
    chk("rst_mid_busy", 1, busy_b, 0);
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 2; i++) begin
      hs_pend[i] = 1'b0; dn_sched[i] = 1'b0; dn_now[i] = 1'b0;
      ovr_m[i] = 1'b0; fnum_m[i] = 0;
    end
    @(posedge clk); #2 rst_n = 1'b1;
    do_load(pack8(v2), 4'd8);
    wait_idle();

    do_load(pack8(v1), 4'd12);
    wait_idle();
    do_load(pack8(v1), 4'd0);
    wait_idle();

    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      r = rand_lanes();
      do_load(r, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        do_load(rand_lanes(), 4'($urandom_range(0, 15)));
      end
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
